// File: rtl/arcade_input_gen.sv
// arcade_input_gen: registers player joystick words into active-low arcade ports with SOCD
// cleaning and queued coin pulses; autofire is built only when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_gen #(
   parameter int         NUM_PLAYERS = 2,
   parameter int         NUM_BTN     = 3,
   parameter int         COIN_PULSE  = 4800000,
   parameter int         COIN_GAP    = 2400000,
   parameter int         COIN_QUEUE  = 3,
   parameter int         AF_DIV      = 1600000,
   parameter logic [3:0] AF_MASK     = 4'b0001
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic [16*NUM_PLAYERS-1:0]  joy,
   input  logic                       socd_clean,
   input  logic                       af_en,
   output logic [8*NUM_PLAYERS-1:0]   inp,
   output logic [7:0]                 sys
);

   localparam int          TMAX       = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
   localparam int          TW         = $clog2(TMAX + 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_PULSE - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP - 1);
   localparam logic [2:0]  QUEUE_MAX  = 3'(COIN_QUEUE);
   localparam logic [3:0]  BTN_EN     = 4'((1 << NUM_BTN) - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} chute_state_t;

   logic [16*NUM_PLAYERS-1:0] joy_q;
   logic                      socd_q;
   logic                      af_en_q;
   logic                      in_valid;
   logic [3:0]                af_gate;
   logic [1:0]                coin_now;
   logic [1:0]                coin_low_nxt;
   logic [8*NUM_PLAYERS-1:0]  inp_nxt;
   logic [7:0]                sys_nxt;
   logic                      unused_bits;

   assign unused_bits = ^{joy_q, af_en_q};

   // in_valid marks that joy_q holds a real sample rather than its reset value.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         joy_q    <= '0;
         socd_q   <= 1'b0;
         af_en_q  <= 1'b0;
         in_valid <= 1'b0;
      end else begin
         joy_q    <= joy;
         socd_q   <= socd_clean;
         af_en_q  <= af_en;
         in_valid <= 1'b1;
      end
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int           AW      = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
   localparam logic [AW-1:0] AF_LAST = AW'(AF_DIV - 1);

   logic [AW-1:0] af_timer;
   logic          af_phase;

   // The phase timer free-runs regardless of af_en so toggling af_en never resyncs it.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         af_timer <= '0;
         af_phase <= 1'b0;
      end else if (af_timer == AF_LAST) begin
         af_timer <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_timer <= af_timer + 1'b1;
      end
   end

   assign af_gate = af_en_q ? (~AF_MASK | {4{af_phase}}) : 4'hF;
`else
   assign af_gate = 4'hF;
`endif

   always_comb begin
      coin_now = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (p[0]) coin_now[1] = coin_now[1] | joy_q[16*p + 13];
         else      coin_now[0] = coin_now[0] | joy_q[16*p + 13];
      end
   end

   for (genvar c = 0; c < 2; c++) begin : g_chute
      chute_state_t  state, state_nxt;
      logic [TW-1:0] timer, timer_nxt;
      logic [2:0]    pending, pending_nxt;
      logic          coin_prev;
      logic          armed;
      logic          coin_edge;
      logic          take;

      // A coin line only arms once it has been seen low after reset, so a held coin never counts.
      assign coin_edge = coin_now[c] & ~coin_prev & armed;

      always_comb begin
         state_nxt   = state;
         timer_nxt   = timer;
         pending_nxt = pending;
         take        = 1'b0;
         case (state)
            ST_IDLE: begin
               if (pending != 3'd0) begin
                  state_nxt = ST_PULSE;
                  timer_nxt = '0;
                  take      = 1'b1;
               end
            end
            ST_PULSE: begin
               if (timer == PULSE_LAST) begin
                  state_nxt = ST_GAP;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            ST_GAP: begin
               // A queued coin leaves the gap straight into the next pulse so the high time is exactly COIN_GAP.
               if (timer == GAP_LAST) begin
                  timer_nxt = '0;
                  if (pending != 3'd0) begin
                     state_nxt = ST_PULSE;
                     take      = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               timer_nxt = '0;
            end
         endcase
         if (coin_edge && !take) begin
            if (pending != QUEUE_MAX) pending_nxt = pending + 3'd1;
         end else if (take && !coin_edge) begin
            pending_nxt = pending - 3'd1;
         end
      end

      always_ff @(posedge clk_sys) begin
         if (!reset_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pending   <= '0;
            coin_prev <= 1'b0;
            armed     <= 1'b0;
         end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            pending   <= pending_nxt;
            coin_prev <= coin_now[c];
            armed     <= armed | (in_valid & ~coin_now[c]);
         end
      end

      assign coin_low_nxt[c] = (state_nxt == ST_PULSE);
   end

   always_comb begin : out_comb
      logic       r, l, u, d;
      logic [3:0] btn;
      inp_nxt = '1;
      sys_nxt = 8'hFF;
      r       = 1'b0;
      l       = 1'b0;
      u       = 1'b0;
      d       = 1'b0;
      btn     = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         r   = joy_q[16*p + 0];
         l   = joy_q[16*p + 1];
         d   = joy_q[16*p + 2];
         u   = joy_q[16*p + 3];
         btn = joy_q[16*p + 4 +: 4] & BTN_EN & af_gate;
         if (socd_q && u && d) begin
            u = 1'b0;
            d = 1'b0;
         end
         if (socd_q && l && r) begin
            l = 1'b0;
            r = 1'b0;
         end
         inp_nxt[8*p +: 8] = ~{l, r, u, d, btn[3], btn[1], btn[0], btn[2]};
         sys_nxt[4 + p]    = ~joy_q[16*p + 12];
      end
      sys_nxt[1:0] = ~coin_low_nxt;
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         inp <= '1;
         sys <= 8'hFF;
      end else begin
         inp <= inp_nxt;
         sys <= sys_nxt;
      end
   end

endmodule

// File: tb/tb_arcade_input_gen.sv
// tb_arcade_input_gen: directed vectors for arcade_input_gen with short coin timing (pulse 10, gap 5)
// and a 4-cycle autofire divider; autofire expectations follow ARCADE_INPUT_AUTOFIRE_EN.
module tb_arcade_input_gen;

   logic         clk_sys = 1'b0;
   logic         reset_n;
   logic [31:0]  joy;
   logic         socd_clean;
   logic         af_en;
   logic [15:0]  inp;
   logic [7:0]   sys;

   int           check_count = 0;
   int           error_count = 0;
   logic [127:0] trace0;
   logic [127:0] trace1;

   typedef struct {
      logic [31:0] j;
      logic        s;
      logic [15:0] exp_inp;
      logic [7:0]  exp_sys;
   } vec_t;

   vec_t vecs[11];

   arcade_input_gen #(
      .NUM_PLAYERS(2),
      .NUM_BTN(3),
      .COIN_PULSE(10),
      .COIN_GAP(5),
      .COIN_QUEUE(3),
      .AF_DIV(4),
      .AF_MASK(4'b0001)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .joy(joy),
      .socd_clean(socd_clean),
      .af_en(af_en),
      .inp(inp),
      .sys(sys)
   );

   always #5 clk_sys = ~clk_sys;

   // Advance n rising edges and settle 1 ns past the last one before anything is sampled.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] j, input logic s, input logic a);
      joy        = j;
      socd_clean = s;
      af_en      = a;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives the two coin lines from per-cycle tap masks; trace[k] holds the chute bit after edge k.
   task automatic coinRun(input logic [127:0] taps0, input logic [127:0] taps1, input int cycles);
      trace0 = '1;
      trace1 = '1;
      for (int k = 0; k < cycles; k++) begin
         joy     = '0;
         joy[13] = taps0[k];
         joy[29] = taps1[k];
         tick(1);
         trace0[k+1] = sys[0];
         trace1[k+1] = sys[1];
      end
      joy = '0;
   endtask

   function automatic int countLow(input logic [127:0] t, input int n);
      int cnt = 0;
      for (int k = 1; k <= n; k++) if (!t[k]) cnt++;
      return cnt;
   endfunction

   function automatic int countPulses(input logic [127:0] t, input int n);
      int cnt = 0;
      for (int k = 1; k <= n; k++) if (!t[k] && t[k-1]) cnt++;
      return cnt;
   endfunction

   function automatic logic expChute3(input int k);
      return !((k >= 3 && k <= 12) || (k >= 18 && k <= 27) || (k >= 33 && k <= 42));
   endfunction

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic       s1 [24];
      logic       s2 [24];
      int         zeros1;
      int         zeros2;
      int         diffs;

      vecs[0]  = '{32'h0000_000C, 1'b1, 16'hFFFF, 8'hFF};
      vecs[1]  = '{32'h0000_000C, 1'b0, 16'hFFCF, 8'hFF};
      vecs[2]  = '{32'h0003_0000, 1'b1, 16'hFFFF, 8'hFF};
      vecs[3]  = '{32'h0003_0000, 1'b0, 16'h3FFF, 8'hFF};
      vecs[4]  = '{32'h0000_000B, 1'b1, 16'hFFDF, 8'hFF};
      vecs[5]  = '{32'h00F0_0000, 1'b0, 16'hF8FF, 8'hFF};
      vecs[6]  = '{32'h0000_0020, 1'b0, 16'hFFFB, 8'hFF};
      vecs[7]  = '{32'h0000_0040, 1'b0, 16'hFFFE, 8'hFF};
      vecs[8]  = '{32'h0005_0010, 1'b1, 16'hAFFD, 8'hFF};
      vecs[9]  = '{32'h1000_1000, 1'b0, 16'hFFFF, 8'hCF};
      vecs[10] = '{32'h0000_1000, 1'b0, 16'hFFFF, 8'hEF};

      reset_n = 1'b0;
      applyStimulus(32'h1008_1008, 1'b0, 1'b0);
      tick(3);
      checkOutput("reset_inp", inp, 16'hFFFF);
      checkOutput("reset_sys", sys, 8'hFF);
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      checkOutput("idle_inp", inp, 16'hFFFF);
      checkOutput("idle_sys", sys, 8'hFF);

      applyStimulus(32'h0000_0008, 1'b0, 1'b0);
      tick(1);
      checkOutput("up_press_c1", inp[5], 1'b1);
      tick(1);
      checkOutput("up_press_c2", inp[7:0], 8'hDF);
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("up_rel_c1", inp[5], 1'b0);
      tick(1);
      checkOutput("up_rel_c2", inp[5], 1'b1);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].j, vecs[i].s, 1'b0);
         tick(2);
         checkOutput($sformatf("vec%0d_inp", i), inp, vecs[i].exp_inp);
         checkOutput($sformatf("vec%0d_sys", i), sys, vecs[i].exp_sys);
      end

      applyStimulus(32'h0000_0030, 1'b0, 1'b1);
      tick(4);
      zeros1 = 0;
      zeros2 = 0;
      for (int i = 0; i < 24; i++) begin
         tick(1);
         s1[i] = inp[1];
         s2[i] = inp[2];
         if (!s1[i]) zeros1++;
         if (!s2[i]) zeros2++;
      end
      diffs = 0;
      for (int i = 0; i < 20; i++) if (s1[i] == s1[i+4]) diffs++;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      checkOutput("af_btn1_low_cycles", zeros1, 12);
      checkOutput("af_btn1_half_period", diffs, 0);
`else
      checkOutput("af_btn1_low_cycles", zeros1, 24);
      checkOutput("af_btn1_unchanged_runs", diffs, 20);
`endif
      checkOutput("af_btn2_low_cycles", zeros2, 24);
      applyStimulus(32'h0000_0030, 1'b0, 1'b0);
      tick(3);
      zeros1 = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (!inp[1]) zeros1++;
      end
      checkOutput("af_off_btn1_low_cycles", zeros1, 16);
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick(4);

      coinRun(128'h15, 128'h0, 60);
      for (int k = 1; k <= 55; k++)
         checkOutput($sformatf("coin3_c%0d", k), trace0[k], expChute3(k));
      checkOutput("coin3_chute2_low", countLow(trace1, 60), 0);

      coinRun(128'h1551, 128'h0, 90);
      checkOutput("queue_pulses", countPulses(trace0, 90), 4);
      checkOutput("queue_low_cycles", countLow(trace0, 90), 40);

      coinRun(128'h1, 128'h1, 40);
      checkOutput("both_c2_chute1", trace0[2], 1'b1);
      checkOutput("both_c3_chute1", trace0[3], 1'b0);
      checkOutput("both_c3_chute2", trace1[3], 1'b0);
      checkOutput("both_chute1_low", countLow(trace0, 40), 10);
      checkOutput("both_chute2_low", countLow(trace1, 40), 10);

      coinRun(128'h3FFF_FFFF, 128'h0, 60);
      checkOutput("held_pulses", countPulses(trace0, 60), 1);
      checkOutput("held_low_cycles", countLow(trace0, 60), 10);

      coinRun(128'h15, 128'h0, 20);
      checkOutput("rst_pulse2_active", trace0[20], 1'b0);
      reset_n = 1'b0;
      tick(1);
      checkOutput("rst_mid_pulse_sys", sys, 8'hFF);
      checkOutput("rst_mid_pulse_inp", inp, 16'hFFFF);
      tick(1);
      reset_n = 1'b1;
      coinRun(128'h0, 128'h0, 60);
      checkOutput("rst_no_more_pulses", countLow(trace0, 60), 0);

      reset_n = 1'b0;
      applyStimulus(32'h0000_2000, 1'b0, 1'b0);
      tick(3);
      reset_n = 1'b1;
      coinRun(128'h7FFF, 128'h0, 40);
      checkOutput("held_thru_reset_low", countLow(trace0, 40), 0);
      coinRun(128'h1, 128'h0, 20);
      checkOutput("after_rearm_c2", trace0[2], 1'b1);
      checkOutput("after_rearm_c3", trace0[3], 1'b0);
      checkOutput("after_rearm_pulses", countPulses(trace0, 20), 1);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/arcade_input_gen.md
ARCADE_INPUT_GEN -- requirements
Module: arcade_input_gen

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of player ports (1..4).
REQ-002 Parameter NUM_BTN, default 3, fire buttons per player mapped to output (1..4).
REQ-003 Parameter COIN_PULSE, default 4800000, cycles a coin line is held active (100 ms at 48 MHz).
REQ-004 Parameter COIN_GAP, default 2400000, minimum inactive cycles between coin pulses on one chute.
REQ-005 Parameter COIN_QUEUE, default 3, maximum pending coins per chute (1..7).
REQ-006 Parameter AF_DIV, default 1600000, cycles per autofire phase toggle.
REQ-007 Parameter AF_MASK, default 4'b0001, per-button autofire eligibility, shared by all players.
REQ-008 clk_sys  in  1  system clock (48 MHz); sole clock of the block.
REQ-009 reset_n  in  1  reset, synchronous, active-low.
REQ-010 joy  in  16*NUM_PLAYERS  per-player joystick word, active-high: [0]R [1]L [2]D [3]U [7:4]btn4..1 reversed as btn1=[4], [12]start, [13]coin, others ignored.
REQ-011 socd_clean  in  1  1 = cancel opposing directions.
REQ-012 af_en  in  1  1 = autofire active on AF_MASK buttons.
REQ-013 inp  out  8*NUM_PLAYERS  per-player port, active-low: {L,R,U,D,btn4,btn2,btn1,btn3}; unused buttons read 1.
REQ-014 sys  out  8  system port, active-low: [0]coin chute 1, [1]coin chute 2, [3:2]=1, [4+p]start of player p, unused bits 1.

Function
REQ-015 All joy bits, socd_clean and af_en shall be registered once on clk_sys before use; inp and sys are registered outputs.
REQ-016 Direction/button/start latency from joy change to inp/sys change shall be exactly 2 cycles.
REQ-017 With socd_clean=1, U and D both pressed shall output neither; L and R both pressed shall output neither; with socd_clean=0 raw values pass.
REQ-018 Chute 1 is fed by player 0 coin; chute 2 by player 1 coin; players 2..3 coins OR into chute 1 and 2 respectively.
REQ-019 A coin rising edge (registered value 1, previous 0) shall increment that chute's pending counter, saturating at COIN_QUEUE; edges while full are dropped.
REQ-020 Each chute FSM: IDLE -> PULSE when pending>0 (pending decremented same cycle); PULSE holds coin bit 0 for exactly COIN_PULSE cycles -> GAP; GAP holds coin bit 1 for exactly COIN_GAP cycles -> IDLE.
REQ-021 Simultaneous edge and IDLE->PULSE decrement shall leave pending unchanged.
REQ-022 Coin held high for any duration shall count as one coin.
REQ-023 From IDLE with pending=0, sys coin bit shall go 0 exactly 3 cycles after the joy coin bit rises.
REQ-024 Pulse and gap counters shall be wide enough for their parameters; no wrap-around within one state.
REQ-025 Chutes operate independently; simultaneous coins on both chutes produce overlapping pulses.

Reset
REQ-026 While reset_n=0 at a clk_sys edge: inp all 1, sys 8'hFF, pending counters 0, FSMs IDLE, all timers 0, autofire phase 0, input registers 0.
REQ-027 Reset mid-PULSE shall end the pulse on the next edge and discard all pending coins.
REQ-028 First coin edge detection after reset release requires a 0->1 transition; a coin held through reset shall not count.

Configuration
REQ-029 Macro ARCADE_INPUT_AUTOFIRE_EN defined: AF_DIV timer toggles phase every AF_DIV cycles; when af_en=1 an AF_MASK button output = pressed AND phase; non-masked buttons pass unchanged.
REQ-030 Macro ARCADE_INPUT_AUTOFIRE_EN undefined: autofire timer/phase logic absent, af_en ignored, all buttons pass unchanged.
REQ-031 Toggling af_en shall not reset the phase timer.

Verification
REQ-032 NUM_PLAYERS=2, joy[3]=1 (P0 up) at cycle 0 -> inp[5]=0 from cycle 2; joy[3]=0 -> inp[5]=1 two cycles later.
REQ-033 socd_clean=1, P0 U+D pressed -> inp[5:4]=2'b11; socd_clean=0 -> inp[5:4]=2'b00.
REQ-034 COIN_PULSE=10, COIN_GAP=5, three P0 coin taps within 4 cycles -> sys[0] three 10-cycle low pulses separated by 5 high cycles, first low at cycle 3.
REQ-035 COIN_QUEUE=3, five taps during first pulse -> exactly 4 total pulses (1 active + 3 queued).
REQ-036 Assert reset_n=0 during 2nd of 3 queued pulses -> sys=8'hFF next edge, no further pulses after release.
REQ-037 Macro defined, AF_DIV=4, af_en=1, btn1 held -> inp[1] alternates 4 cycles 0 / 4 cycles 1; btn2 steady 0; macro undefined -> btn1 steady 0.
